// File: rtl/clk_divider_bank.sv
// Bank of NUM_CH run-time programmable clock dividers on the PLL clock, gated by a filtered
// PLL lock; each channel emits a one-cycle enable and a 50% toggled clock.
module clk_divider_bank #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned LOCK_FILTER = 16,
  localparam int unsigned SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in1_i,
  input  logic              rst_n_i,
  input  logic              lock_in_i,
  input  logic              sync_i,
  input  logic              div_wvalid_i,
  input  logic [SEL_W-1:0]  div_wsel_i,
  input  logic [DIV_W-1:0]  div_wdata_i,
  output logic              div_wready_o,
  output logic [NUM_CH-1:0] pending_o,
  output logic              locked_o,
  output logic [NUM_CH-1:0] ce_out_o,
  output logic [NUM_CH-1:0] clk_out_o
);

  localparam int unsigned FLT_W = $clog2(LOCK_FILTER + 1);

  logic             lock_s1_q, lock_s2_q;
  logic [FLT_W-1:0] flt_q, flt_d;
  logic             locked_q, locked_d;

  logic [DIV_W-1:0]  cnt_q  [NUM_CH];
  logic [DIV_W-1:0]  cnt_d  [NUM_CH];
  logic [DIV_W-1:0]  div_q  [NUM_CH];
  logic [DIV_W-1:0]  div_d  [NUM_CH];
  logic [DIV_W-1:0]  hold_q [NUM_CH];
  logic [DIV_W-1:0]  hold_d [NUM_CH];
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] ce_q, ce_d;
  logic [NUM_CH-1:0] clk_q, clk_d;

  logic              wr_acc_c;
  logic [NUM_CH-1:0] wr_hit_c, wrap_c, apply_c;

  // Lock filter: saturating run-length of synchronised lock; the falling edge is unfiltered.
  always_comb begin
    flt_d = '0;
    if (lock_s2_q) begin
      flt_d = (flt_q == FLT_W'(LOCK_FILTER)) ? flt_q : flt_q + FLT_W'(1);
    end
    locked_d = lock_s2_q && (flt_q >= FLT_W'(LOCK_FILTER - 1));
  end

  always_comb begin
    div_wready_o = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (div_wsel_i == SEL_W'(k)) div_wready_o = ~pending_q[k];
    end
  end

  assign wr_acc_c = div_wvalid_i && div_wready_o;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign wr_hit_c[k] = wr_acc_c && (div_wsel_i == SEL_W'(k));
    // The N-1 compare only applies to a running channel, so N=0 cannot underflow.
    assign wrap_c[k]   = (div_q[k] != '0) && (cnt_q[k] == div_q[k] - DIV_W'(1));
    assign apply_c[k]  = pending_q[k] &&
                         (!locked_q || sync_i || (div_q[k] == '0) || wrap_c[k]);
  end

  always_comb begin
    pending_d = pending_q;
    ce_d      = '0;
    clk_d     = clk_q;
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_d[k]  = cnt_q[k];
      div_d[k]  = div_q[k];
      hold_d[k] = hold_q[k];
      if (apply_c[k]) begin
        div_d[k]     = hold_q[k];
        pending_d[k] = 1'b0;
      end
      // A write coinciding with a live SYNC bypasses the holding register.
      if (wr_hit_c[k]) begin
        if (locked_q && sync_i) begin
          div_d[k] = div_wdata_i;
        end else begin
          hold_d[k]    = div_wdata_i;
          pending_d[k] = 1'b1;
        end
      end
      if (!locked_q || sync_i) begin
        cnt_d[k] = '0;
        clk_d[k] = 1'b0;
      end else if (div_q[k] == '0) begin
        cnt_d[k] = '0;
      end else begin
        ce_d[k]  = wrap_c[k];
        clk_d[k] = clk_q[k] ^ wrap_c[k];
        cnt_d[k] = wrap_c[k] ? '0 : cnt_q[k] + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in1_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
      flt_q     <= '0;
      locked_q  <= 1'b0;
      pending_q <= '0;
      ce_q      <= '0;
      clk_q     <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k]  <= '0;
        div_q[k]  <= DIV_W'(1) << k;
        hold_q[k] <= '0;
      end
    end else begin
      lock_s1_q <= lock_in_i;
      lock_s2_q <= lock_s1_q;
      flt_q     <= flt_d;
      locked_q  <= locked_d;
      pending_q <= pending_d;
      ce_q      <= ce_d;
      clk_q     <= clk_d;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k]  <= cnt_d[k];
        div_q[k]  <= div_d[k];
        hold_q[k] <= hold_d[k];
      end
    end
  end

  assign pending_o = pending_q;
  assign locked_o  = locked_q;
  assign ce_out_o  = ce_q;
  assign clk_out_o = clk_q;

endmodule

// File: tb/tb_clk_divider_bank.sv
// Randomised bench for clk_divider_bank against a phase-arithmetic reference model.
module tb_clk_divider_bank;

  localparam int NUM_CH      = 4;
  localparam int DIV_W       = 8;
  localparam int LOCK_FILTER = 16;
  localparam int SEL_W       = 2;

  logic              clk = 1'b0;
  logic              rst_n, lock_in, sync, wvalid;
  logic [SEL_W-1:0]  wsel;
  logic [DIV_W-1:0]  wdata;
  logic              wready, locked;
  logic [NUM_CH-1:0] pending, ce_out, clk_out;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model: each channel's enables fall on start + m*N; clk level is the enable count parity.
  int              m_n     [NUM_CH];
  int              m_hold  [NUM_CH];
  int              m_start [NUM_CH];
  bit [NUM_CH-1:0] m_pend, m_ce, m_clk;
  bit              m_locked;
  int              run0, run1, run2;
  int              t;

  always #5 clk = ~clk;

  clk_divider_bank #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_FILTER(LOCK_FILTER)
  ) dut (
    .clk_in1_i   (clk),
    .rst_n_i     (rst_n),
    .lock_in_i   (lock_in),
    .sync_i      (sync),
    .div_wvalid_i(wvalid),
    .div_wsel_i  (wsel),
    .div_wdata_i (wdata),
    .div_wready_o(wready),
    .pending_o   (pending),
    .locked_o    (locked),
    .ce_out_o    (ce_out),
    .clk_out_o   (clk_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return !m_pend[wsel];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_n[k]     = 1 << k;
      m_hold[k]  = 0;
      m_start[k] = 0;
    end
    m_pend   = '0;
    m_ce     = '0;
    m_clk    = '0;
    m_locked = 1'b0;
    run0 = 0; run1 = 0; run2 = 0;
    t = 0;
  endtask

  task automatic model_step();
    bit lp, acc, ap;
    t++;
    lp  = m_locked;
    acc = wvalid && exp_ready();
    run2 = run1;
    run1 = run0;
    run0 = lock_in ? run0 + 1 : 0;
    for (int k = 0; k < NUM_CH; k++) begin
      ap = 1'b0;
      m_ce[k] = 1'b0;
      if (!lp || sync) begin
        m_clk[k]   = 1'b0;
        m_start[k] = t;
        ap         = m_pend[k];
      end else if (m_n[k] == 0) begin
        m_start[k] = t;
        ap         = m_pend[k];
      end else if ((t - m_start[k]) % m_n[k] == 0) begin
        m_ce[k]  = 1'b1;
        m_clk[k] = ~m_clk[k];
        if (m_pend[k]) begin
          ap         = 1'b1;
          m_start[k] = t;
        end
      end
      if (ap) begin
        m_n[k]    = m_hold[k];
        m_pend[k] = 1'b0;
      end
      if (acc && (int'(wsel) == k)) begin
        if (lp && sync) begin
          m_n[k] = int'(wdata);
        end else begin
          m_hold[k] = int'(wdata);
          m_pend[k] = 1'b1;
        end
      end
    end
    m_locked = (run2 >= LOCK_FILTER);
  endtask

  // One clock: drive inputs after the falling edge, check on the next falling edge.
  task automatic cyc(input bit lk, input bit sy, input bit v,
                     input logic [SEL_W-1:0] s, input logic [DIV_W-1:0] d);
    lock_in = lk;
    sync    = sy;
    wvalid  = v;
    wsel    = s;
    wdata   = d;
    #1;
    check_eq("wready", 32'(wready), 32'(exp_ready()));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("locked",  32'(locked),  32'(m_locked));
    check_eq("pending", 32'(pending), 32'(m_pend));
    check_eq("ce_out",  32'(ce_out),  32'(m_ce));
    check_eq("clk_out", 32'(clk_out), 32'(m_clk));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_ce",      32'(ce_out),  32'(0));
    check_eq("rst_clk",     32'(clk_out), 32'(0));
    check_eq("rst_pending", 32'(pending), 32'(0));
    check_eq("rst_locked",  32'(locked),  32'(0));
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int rise;
    int drop;
    rst_n   = 1'b0;
    lock_in = 1'b0;
    sync    = 1'b0;
    wvalid  = 1'b0;
    wsel    = '0;
    wdata   = '0;
    do_reset();

    // Lock held high from reset release: measure when LOCKED rises.
    rise = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b1, 1'b0, 1'b0, '0, '0);
      if (locked && rise == 0) rise = i;
    end
    check_eq("lock_rise_cycle", 32'(rise), 32'(LOCK_FILTER + 2));

    // Lock dropout and re-filter.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0);
    idle(40);

    // ch2 N=4 -> 3 mid-period, then a second write held while stalled.
    idle(2);
    cyc(1'b1, 1'b0, 1'b1, 2'd2, 8'd3);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1, 2'd2, 8'd5);
    idle(15);

    // ch1 stopped, then restarted at N=5.
    cyc(1'b1, 1'b0, 1'b1, 2'd1, 8'd0);
    idle(10);
    cyc(1'b1, 1'b0, 1'b1, 2'd1, 8'd5);
    idle(15);

    // SYNC with a write to ch3.
    cyc(1'b1, 1'b1, 1'b1, 2'd3, 8'd6);
    idle(20);

    // Queue writes on ch0 and ch2, then reset with them outstanding.
    cyc(1'b1, 1'b0, 1'b1, 2'd0, 8'd9);
    idle(2);
    cyc(1'b1, 1'b0, 1'b1, 2'd0, 8'd3);
    cyc(1'b1, 1'b0, 1'b1, 2'd2, 8'd7);
    do_reset();
    idle(40);

    // Randomised traffic with occasional lock drops, SYNC pulses and a mid-run reset.
    drop = 0;
    for (int i = 0; i < 1500; i++) begin
      if (drop > 0) drop--;
      else if ($urandom_range(0, 199) == 0) drop = int'($urandom_range(1, 6));
      if (i == 750) do_reset();
      cyc(drop == 0,
          $urandom_range(0, 39) == 0,
          $urandom_range(0, 2) == 0,
          SEL_W'($urandom_range(0, NUM_CH - 1)),
          ($urandom_range(0, 7) == 0) ? DIV_W'(0) : DIV_W'($urandom_range(1, 9)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
